// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Data-memory access stage of the JoSDC core, upstream of the writeback 3:1 mux
// (rdata_out drives its y input). It accepts one load/store per start pulse and
// runs a req/ack handshake with data memory. Loads are lane-extracted and
// sign- or zero-extended. Stores are replicated across byte lanes and qualified
// by byte enables.
//
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word ops.
// A trapped op skips the memory access and retires with misalign=1.
//
// Ports
//   clk        core clock, all state updates on rising edge
//   rst        synchronous, active-high reset
//   start      EX stage presents a valid memory op this cycle
//   we         1=store, 0=load
//   size       00=byte, 01=half, 10/11=word
//   sign_ext   loads only: 1=sign-extend, 0=zero-extend
//   addr       byte address
//   wdata      store data (low bits used for byte/half)
//   busy       stall request (combinational, includes start)
//   done       one-cycle retire pulse
//   rdata_out  extended load result, held until the next load retires
//   mem_req    memory request, held until mem_ack
//   mem_we     memory write enable
//   mem_addr   word-aligned address
//   mem_wdata  store data replicated across lanes
//   mem_be     byte enables
//   mem_ack    memory completion (read data valid in the same cycle)
//   mem_rdata  memory read word
//   misalign   misaligned-op flag, valid with done (MISALIGN_TRAP_EN only)
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int n  = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          we,
  input  logic [1:0]    size,
  input  logic          sign_ext,
  input  logic [AW-1:0] addr,
  input  logic [n-1:0]  wdata,
  output logic          busy,
  output logic          done,
  output logic [n-1:0]  rdata_out,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [n-1:0]  mem_wdata,
  output logic [3:0]    mem_be,
  input  logic          mem_ack,
  input  logic [n-1:0]  mem_rdata
`ifdef MISALIGN_TRAP_EN
  ,
  output logic          misalign
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            capture;
  logic [1:0]      size_q;
  logic            sign_q;
  logic [1:0]      lane_q;
  logic            mem_we_q;
  logic [AW-1:0]   mem_addr_q;
  logic [n-1:0]    mem_wdata_q;
  logic [3:0]      mem_be_q;
  logic [n-1:0]    rdata_q, rdata_d;
  logic [3:0]      be_in;
  logic [n-1:0]    wdata_rep;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [n-1:0]    load_ext;
  logic            misaligned_in;

`ifdef MISALIGN_TRAP_EN
  logic            misalign_q, misalign_d;

  assign misaligned_in = ((size == 2'b01) && addr[0]) ||
                         (size[1] && (addr[1:0] != 2'b00));
`else
  assign misaligned_in = 1'b0;
`endif

  // Byte enables and lane replication are computed from the incoming op so
  // they can be registered directly at capture time.
  always_comb begin
    be_in     = 4'b1111;
    wdata_rep = wdata;
    case (size)
      2'b00: begin
        be_in     = 4'(4'b0001 << addr[1:0]);
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_in     = addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction uses the latched lane/size so mem_rdata is consumed in the
  // ack cycle without depending on the (possibly changed) input port values.
  always_comb begin
    case (lane_q)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   load_ext = {{(n-8){sign_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{(n-16){sign_q & half_sel[15]}}, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    rdata_d = rdata_q;
`ifdef MISALIGN_TRAP_EN
    misalign_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          capture = 1'b1;
          // A trapped op retires straight away and never touches memory.
          state_d = misaligned_in ? S_DONE : S_ACCESS;
`ifdef MISALIGN_TRAP_EN
          misalign_d = misaligned_in;
`endif
        end
      end
      S_ACCESS: begin
        if (mem_ack) begin
          state_d = S_DONE;
          if (!mem_we_q) rdata_d = load_ext;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      size_q      <= 2'b00;
      sign_q      <= 1'b0;
      lane_q      <= 2'b00;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= 4'b0000;
      rdata_q     <= '0;
`ifdef MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
`ifdef MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
      if (capture) begin
        size_q      <= size;
        sign_q      <= sign_ext;
        lane_q      <= addr[1:0];
        mem_we_q    <= we;
        mem_addr_q  <= {addr[AW-1:2], 2'b00};
        mem_wdata_q <= wdata_rep;
        mem_be_q    <= be_in;
      end
    end
  end

  // busy includes start so the front-end stalls in the same cycle it issues.
  assign busy      = start | (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign mem_req   = (state_q == S_ACCESS);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign rdata_out = rdata_q;
`ifdef MISALIGN_TRAP_EN
  assign misalign  = misalign_q;
`endif

endmodule
